// File: rtl/qspi_arb_pkg.sv
// Shared types and constants for the QSPI access arbiter.
// State/owner encodings plus a counter-width helper.
package qspi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_XIP,
    OWN_IND
  } owner_t;

  localparam logic [7:0] XIP_CMD_DEF = 8'hEB;

  // Width needed to hold the larger of two counts.
  function automatic int cnt_w(
    input int a,
    input int b
  );
    int m;
    m = (a > b) ? a : b;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/qspi_arb_timer.sv
// Shared down-counter: CS-gap timer in IDLE, launch watchdog in LAUNCH.
// Ports: clk, rst_n, load, load_val, en (decrement), zero (count is 0).
module qspi_arb_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/qspi_access_arb.sv
// Arbitrates the QSPI engine between XIP bursts and indirect commands.
// Ports: xip_* / ind_* requesters, qspi_busy_in, seq_* payload, err.
module qspi_access_arb
  import qspi_arb_pkg::*;
#(
  parameter int         ADDR_W     = 32,
  parameter int         LEN_W      = 8,
  parameter logic [7:0] XIP_CMD    = XIP_CMD_DEF,
  parameter int         STARVE_LIM = 16,
  parameter int         CS_GAP     = 2,
  parameter int         START_TO   = 8
) (
  input  logic              h_clk,
  input  logic              h_rstn,
  input  logic              xip_req_in,
  input  logic [ADDR_W-1:0] xip_addr_in,
  input  logic [LEN_W-1:0]  xip_len_in,
  input  logic              xip_abort_in,
  output logic              xip_gnt_out,
  output logic              xip_done_out,
  input  logic              ind_req_in,
  input  logic [ADDR_W-1:0] ind_addr_in,
  input  logic [LEN_W-1:0]  ind_len_in,
  input  logic [7:0]        ind_cmd_in,
  output logic              ind_gnt_out,
  output logic              ind_done_out,
  input  logic              qspi_busy_in,
  output logic              start_new_xip_seq_out,
  output logic [ADDR_W-1:0] seq_addr_out,
  output logic [LEN_W-1:0]  seq_len_out,
  output logic [7:0]        seq_cmd_out,
  output logic              seq_is_ind_out,
  output logic              seq_abort_out,
  output logic              arb_err_out,
  input  logic              err_clr_in
);

  localparam int TW = cnt_w(CS_GAP, START_TO);
  localparam int SW = $clog2(STARVE_LIM + 1);

  localparam logic [TW-1:0] GAP_V = TW'(CS_GAP);
  // Watchdog counts down to zero, so START_TO
  // launch cycles need START_TO-1 loaded.
  localparam logic [TW-1:0] TO_V =
    TW'((START_TO > 0) ? START_TO - 1 : 0);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIM);

  arb_state_t    state;
  owner_t        owner;
  logic [SW-1:0] starve_cnt;

  logic tmr_zero;
  logic tmr_load;
  logic tmr_en;
  logic [TW-1:0] tmr_val;

  logic grant;
  logic pick_ind;
  logic ind_win;
  logic xip_abt;
  logic to_hit;

  always_comb begin
    pick_ind = 1'b0;
    grant    = 1'b0;
    if (ind_req_in && (starve_cnt >= SLIM))
      pick_ind = 1'b1;
    else if (!xip_req_in && ind_req_in)
      pick_ind = 1'b1;
    if ((state == IDLE) && tmr_zero)
      grant = xip_req_in || ind_req_in;
  end

  assign ind_win = grant && pick_ind;

  // Abort only matters for an XIP owner mid-sequence.
  assign xip_abt = xip_abort_in &&
                   (owner == OWN_XIP) &&
                   ((state == LAUNCH) ||
                    (state == BUSY));

  assign to_hit = (state == LAUNCH) &&
                  !qspi_busy_in &&
                  !xip_abt &&
                  tmr_zero;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TO_V;
    if (state == DONE) begin
      tmr_load = 1'b1;
      tmr_val  = GAP_V;
    end else if (grant) begin
      tmr_load = 1'b1;
      tmr_val  = TO_V;
    end
  end

  assign tmr_en = (state == IDLE) ||
                  (state == LAUNCH);

  qspi_arb_timer #(
    .W (TW)
  ) u_timer (
    .clk      (h_clk),
    .rst_n    (h_rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge h_clk or negedge h_rstn) begin
    if (!h_rstn) begin
      starve_cnt <= '0;
    end else if (!ind_req_in || ind_win) begin
      starve_cnt <= '0;
    end else if (starve_cnt < SLIM) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // A timeout in the same cycle as a clear wins.
  always_ff @(posedge h_clk or negedge h_rstn) begin
    if (!h_rstn) begin
      arb_err_out <= 1'b0;
    end else if (to_hit) begin
      arb_err_out <= 1'b1;
    end else if (err_clr_in) begin
      arb_err_out <= 1'b0;
    end
  end

  always_ff @(posedge h_clk or negedge h_rstn) begin
    if (!h_rstn) begin
      state                 <= IDLE;
      owner                 <= OWN_XIP;
      xip_gnt_out           <= 1'b0;
      ind_gnt_out           <= 1'b0;
      xip_done_out          <= 1'b0;
      ind_done_out          <= 1'b0;
      start_new_xip_seq_out <= 1'b0;
      seq_addr_out          <= '0;
      seq_len_out           <= '0;
      seq_cmd_out           <= '0;
      seq_abort_out         <= 1'b0;
    end else begin
      xip_gnt_out  <= 1'b0;
      ind_gnt_out  <= 1'b0;
      xip_done_out <= 1'b0;
      ind_done_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            start_new_xip_seq_out <= 1'b1;
            state <= LAUNCH;
            if (pick_ind) begin
              ind_gnt_out  <= 1'b1;
              owner        <= OWN_IND;
              seq_addr_out <= ind_addr_in;
              seq_len_out  <= ind_len_in;
              seq_cmd_out  <= ind_cmd_in;
            end else begin
              xip_gnt_out  <= 1'b1;
              owner        <= OWN_XIP;
              seq_addr_out <= xip_addr_in;
              seq_len_out  <= xip_len_in;
              seq_cmd_out  <= XIP_CMD;
            end
          end
        end
        LAUNCH: begin
          if (qspi_busy_in) begin
            start_new_xip_seq_out <= 1'b0;
            state <= BUSY;
            if (xip_abt)
              seq_abort_out <= 1'b1;
          end else if (xip_abt || tmr_zero) begin
            start_new_xip_seq_out <= 1'b0;
            state        <= DONE;
            xip_done_out <= (owner == OWN_XIP);
            ind_done_out <= (owner == OWN_IND);
          end
        end
        BUSY: begin
          if (xip_abt)
            seq_abort_out <= 1'b1;
          if (!qspi_busy_in) begin
            state        <= DONE;
            xip_done_out <= (owner == OWN_XIP);
            ind_done_out <= (owner == OWN_IND);
          end
        end
        DONE: begin
          seq_abort_out <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign seq_is_ind_out = (owner == OWN_IND);

endmodule

// File: tb/tb_qspi_access_arb.sv
// Directed self-checking bench for qspi_access_arb.
// A small responder models qspi_cont busy timing.
module tb_qspi_access_arb;

  logic        h_clk = 1'b0;
  logic        h_rstn;
  logic        xip_req_in;
  logic [31:0] xip_addr_in;
  logic [7:0]  xip_len_in;
  logic        xip_abort_in;
  logic        xip_gnt_out;
  logic        xip_done_out;
  logic        ind_req_in;
  logic [31:0] ind_addr_in;
  logic [7:0]  ind_len_in;
  logic [7:0]  ind_cmd_in;
  logic        ind_gnt_out;
  logic        ind_done_out;
  logic        qspi_busy_in;
  logic        start_new_xip_seq_out;
  logic [31:0] seq_addr_out;
  logic [7:0]  seq_len_out;
  logic [7:0]  seq_cmd_out;
  logic        seq_is_ind_out;
  logic        seq_abort_out;
  logic        arb_err_out;
  logic        err_clr_in;

  qspi_access_arb dut (
    .h_clk                 (h_clk),
    .h_rstn                (h_rstn),
    .xip_req_in            (xip_req_in),
    .xip_addr_in           (xip_addr_in),
    .xip_len_in            (xip_len_in),
    .xip_abort_in          (xip_abort_in),
    .xip_gnt_out           (xip_gnt_out),
    .xip_done_out          (xip_done_out),
    .ind_req_in            (ind_req_in),
    .ind_addr_in           (ind_addr_in),
    .ind_len_in            (ind_len_in),
    .ind_cmd_in            (ind_cmd_in),
    .ind_gnt_out           (ind_gnt_out),
    .ind_done_out          (ind_done_out),
    .qspi_busy_in          (qspi_busy_in),
    .start_new_xip_seq_out (start_new_xip_seq_out),
    .seq_addr_out          (seq_addr_out),
    .seq_len_out           (seq_len_out),
    .seq_cmd_out           (seq_cmd_out),
    .seq_is_ind_out        (seq_is_ind_out),
    .seq_abort_out         (seq_abort_out),
    .arb_err_out           (arb_err_out),
    .err_clr_in            (err_clr_in)
  );

  always #5 h_clk = ~h_clk;

  logic [55:0] outs;
  assign outs = {xip_gnt_out, xip_done_out,
                 ind_gnt_out, ind_done_out,
                 start_new_xip_seq_out,
                 seq_addr_out, seq_len_out,
                 seq_cmd_out, seq_is_ind_out,
                 seq_abort_out, arb_err_out};

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    else
      n_pass++;
  endtask

  // Responder: busy rises rsp_dly cycles after
  // start is seen, stays high rsp_len cycles.
  bit rsp_en = 1'b0;
  int rsp_dly = 1;
  int rsp_len = 1;
  int ph = 0;
  int wc = 0;
  int hc = 0;

  initial begin
    qspi_busy_in = 1'b0;
    forever begin
      @(negedge h_clk);
      if (!rsp_en) begin
        qspi_busy_in = 1'b0;
        ph = 0;
      end else if (ph == 0) begin
        if (start_new_xip_seq_out && !qspi_busy_in) begin
          if (rsp_dly == 0) begin
            qspi_busy_in = 1'b1;
            hc = rsp_len;
            ph = 2;
          end else begin
            wc = rsp_dly;
            ph = 1;
          end
        end
      end else if (ph == 1) begin
        wc--;
        if (wc == 0) begin
          qspi_busy_in = 1'b1;
          hc = rsp_len;
          ph = 2;
        end
      end else begin
        hc--;
        if (hc == 0) begin
          qspi_busy_in = 1'b0;
          ph = 0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge h_clk);
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return xip_gnt_out;
      1:       return xip_done_out;
      2:       return ind_gnt_out;
      default: return ind_done_out;
    endcase
  endfunction

  // Ticks until the chosen pulse is seen.
  task automatic wait_for(
    input  string tag,
    input  int    w,
    input  int    budget,
    output int    t
  );
    t = 0;
    forever begin
      tick();
      t++;
      if (sel(w)) break;
      if (t >= budget) begin
        chk({tag, "_timeout"}, 0, 1);
        break;
      end
    end
  endtask

  task automatic do_reset();
    h_rstn       = 1'b0;
    rsp_en       = 1'b0;
    xip_req_in   = 1'b0;
    xip_abort_in = 1'b0;
    ind_req_in   = 1'b0;
    err_clr_in   = 1'b0;
    xip_addr_in  = '0;
    xip_len_in   = '0;
    ind_addr_in  = '0;
    ind_len_in   = '0;
    ind_cmd_in   = '0;
    repeat (2) tick();
    h_rstn = 1'b1;
    tick();
  endtask

  int t;
  int nx;
  int sc;
  logic any;

  initial begin
    do_reset();
    h_rstn = 1'b0;
    repeat (2) tick();
    chk("rst_outs", outs, 0);
    h_rstn = 1'b1;
    tick();

    // Basic XIP burst.
    rsp_en = 1'b1;
    rsp_dly = 2;
    rsp_len = 10;
    xip_addr_in = 32'h1000;
    xip_len_in = 8'd8;
    xip_req_in = 1'b1;
    wait_for("t1_gnt", 0, 20, t);
    chk("t1_gnt", xip_gnt_out, 1);
    chk("t1_addr", seq_addr_out, 32'h1000);
    chk("t1_len", seq_len_out, 8);
    chk("t1_cmd", seq_cmd_out, 8'hEB);
    chk("t1_isind", seq_is_ind_out, 0);
    chk("t1_start", start_new_xip_seq_out, 1);
    xip_req_in = 1'b0;
    wait_for("t1_done", 1, 40, t);
    chk("t1_done_lat", t, 13);
    xip_req_in = 1'b1;
    tick();
    chk("t1_done_pulse", xip_done_out, 0);
    chk("t1_gnt_pulse", xip_gnt_out, 0);
    wait_for("t1_regnt", 0, 20, t);
    chk("t1_gap", t + 1, 4);
    xip_req_in = 1'b0;
    wait_for("t1_done2", 1, 40, t);

    // Starvation guard.
    do_reset();
    rsp_en = 1'b1;
    rsp_dly = 1;
    rsp_len = 1;
    ind_addr_in = 32'h2000_0040;
    ind_len_in = 8'd4;
    ind_cmd_in = 8'h6B;
    xip_addr_in = 32'h3000;
    xip_req_in = 1'b1;
    ind_req_in = 1'b1;
    nx = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (xip_gnt_out) nx++;
      if (ind_gnt_out) break;
    end
    chk("t2_ind_gnt", ind_gnt_out, 1);
    chk("t2_xip_first", nx, 3);
    chk("t2_isind", seq_is_ind_out, 1);
    chk("t2_cmd", seq_cmd_out, 8'h6B);
    chk("t2_addr", seq_addr_out, 32'h2000_0040);
    xip_req_in = 1'b0;
    ind_req_in = 1'b0;
    wait_for("t2_done", 3, 40, t);
    chk("t2_ind_done", ind_done_out, 1);

    // Launch watchdog.
    do_reset();
    xip_req_in = 1'b1;
    wait_for("t3_gnt", 0, 20, t);
    xip_req_in = 1'b0;
    sc = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (xip_done_out) break;
      if (start_new_xip_seq_out) sc++;
    end
    chk("t3_done", xip_done_out, 1);
    chk("t3_start_cyc", sc, 8);
    chk("t3_err", arb_err_out, 1);
    err_clr_in = 1'b1;
    tick();
    err_clr_in = 1'b0;
    chk("t3_err_clr", arb_err_out, 0);

    // Clear held across a timeout.
    repeat (3) tick();
    err_clr_in = 1'b1;
    xip_req_in = 1'b1;
    wait_for("t3b_gnt", 0, 20, t);
    xip_req_in = 1'b0;
    wait_for("t3b_done", 1, 30, t);
    chk("t3b_err_wins", arb_err_out, 1);
    tick();
    chk("t3b_err_clr", arb_err_out, 0);
    err_clr_in = 1'b0;

    // Abort during LAUNCH.
    do_reset();
    xip_req_in = 1'b1;
    wait_for("t4_gnt", 0, 20, t);
    xip_req_in = 1'b0;
    xip_abort_in = 1'b1;
    tick();
    xip_abort_in = 1'b0;
    chk("t4_done", xip_done_out, 1);
    chk("t4_start", start_new_xip_seq_out, 0);
    chk("t4_err", arb_err_out, 0);
    chk("t4_abt", seq_abort_out, 0);

    // Abort during BUSY, XIP owner.
    do_reset();
    rsp_en = 1'b1;
    rsp_dly = 1;
    rsp_len = 10;
    xip_req_in = 1'b1;
    wait_for("t5_gnt", 0, 20, t);
    xip_req_in = 1'b0;
    repeat (3) tick();
    chk("t5_abt_pre", seq_abort_out, 0);
    xip_abort_in = 1'b1;
    tick();
    xip_abort_in = 1'b0;
    chk("t5_abt_set", seq_abort_out, 1);
    tick();
    chk("t5_abt_hold", seq_abort_out, 1);
    wait_for("t5_done", 1, 30, t);
    tick();
    chk("t5_abt_clr", seq_abort_out, 0);

    // Abort ignored for indirect owner.
    do_reset();
    rsp_en = 1'b1;
    rsp_dly = 1;
    rsp_len = 10;
    ind_cmd_in = 8'h38;
    ind_req_in = 1'b1;
    wait_for("t6_gnt", 2, 20, t);
    ind_req_in = 1'b0;
    repeat (3) tick();
    xip_abort_in = 1'b1;
    tick();
    xip_abort_in = 1'b0;
    chk("t6_abt_ign", seq_abort_out, 0);
    wait_for("t6_done", 3, 30, t);
    chk("t6_done", ind_done_out, 1);
    chk("t6_abt_done", seq_abort_out, 0);

    // Asynchronous reset mid-BUSY.
    do_reset();
    rsp_en = 1'b1;
    rsp_dly = 1;
    rsp_len = 10;
    xip_addr_in = 32'h1000;
    xip_req_in = 1'b1;
    wait_for("t7_gnt", 0, 20, t);
    xip_req_in = 1'b0;
    repeat (3) tick();
    chk("t7_pre_addr", seq_addr_out, 32'h1000);
    h_rstn = 1'b0;
    #1;
    chk("t7_async_rst", outs, 0);
    rsp_en = 1'b0;
    tick();
    h_rstn = 1'b1;
    any = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      any = any | (|outs);
    end
    chk("t7_idle", any, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/qspi_access_arb.md
Name: qspi_access_arb

Overview:
- Arbitrates the single QSPI engine (qspi_cont plus QSPI datapath) between two requesters: XIP burst reads from the AHB slave controller, and indirect CSR-programmed commands.
- Registers the winning request's payload and launches the sequence via start_new_xip_seq.
- Tracks qspi_busy to completion, signals done to the owner and enforces a minimum CS-high gap between sequences.
- Adds a starvation guard for indirect requests, an XIP abort path and a launch-timeout watchdog.

Parameters:
ADDR_W, 32, address width of both requesters and seq_addr_out
LEN_W, 8, burst/transfer length field width (beats)
XIP_CMD, 8'hEB, command byte presented on seq_cmd_out for XIP sequences
STARVE_LIM, 16, indirect wait cycles after which indirect beats XIP
CS_GAP, 2, minimum idle cycles between DONE and the next grant
START_TO, 8, max cycles in LAUNCH waiting for qspi_busy_in rise

Ports:
h_clk  in  1  system clock
h_rstn  in  1  async active-low reset
xip_req_in  in  1  XIP request, level, payload stable while high
xip_addr_in  in  ADDR_W  XIP start address
xip_len_in  in  LEN_W  XIP burst length
xip_abort_in  in  1  AHB side abandons current XIP burst
xip_gnt_out  out  1  1-cycle grant pulse to XIP
xip_done_out  out  1  1-cycle completion pulse to XIP
ind_req_in  in  1  indirect request, level
ind_addr_in  in  ADDR_W  indirect address
ind_len_in  in  LEN_W  indirect length
ind_cmd_in  in  8  indirect command byte
ind_gnt_out  out  1  1-cycle grant pulse to indirect
ind_done_out  out  1  1-cycle completion pulse to indirect
qspi_busy_in  in  1  busy from qspi_cont
start_new_xip_seq_out  out  1  launch request to qspi_cont
seq_addr_out  out  ADDR_W  registered address of owner
seq_len_out  out  LEN_W  registered length of owner
seq_cmd_out  out  8  XIP_CMD or registered ind_cmd_in
seq_is_ind_out  out  1  1 = current owner is indirect
seq_abort_out  out  1  abort request to qspi_cont
arb_err_out  out  1  sticky launch-timeout flag
err_clr_in  in  1  clears arb_err_out

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; seq_* 0; starve_cnt 0; gap_cnt 0; err 0.
- States: IDLE, LAUNCH, BUSY, DONE.
- IDLE:
  - Grant only when gap_cnt==0 and a request is high.
  - Winner: indirect if ind_req_in && starve_cnt>=STARVE_LIM; else XIP if xip_req_in; else indirect.
  - On grant, in the same cycle: gnt pulse to the winner; payload registered into seq_* (seq_cmd_out=XIP_CMD for XIP); seq_is_ind_out set; next state LAUNCH.
- starve_cnt: increments (saturating at STARVE_LIM) each cycle ind_req_in=1 and ind not granted; clears on ind grant or when ind_req_in=0.
- LAUNCH:
  - start_new_xip_seq_out=1 (level) until qspi_busy_in=1 is sampled, then BUSY.
  - Timeout counter counts LAUNCH cycles. If START_TO is reached without busy: set arb_err_out, go DONE.
- BUSY: hold seq_*; when qspi_busy_in=0 go DONE.
- DONE:
  - done pulse to owner for exactly 1 cycle.
  - Load gap_cnt=CS_GAP, clear seq_abort_out, go IDLE.
  - gap_cnt decrements to 0 in IDLE.
- Abort:
  - xip_abort_in=1 while owner is XIP in BUSY: latch seq_abort_out=1 until DONE.
  - In LAUNCH before busy: drop start, go DONE directly, no error.
  - xip_abort_in is ignored when the owner is indirect or the state is IDLE.
- Requester rules:
  - A requester deasserts req the cycle after gnt. Still high after DONE is a new request.
  - req dropping before grant: no grant, no error.
- Simultaneous xip_req and ind_req with starve_cnt<STARVE_LIM: XIP wins.
- err_clr_in and a timeout in the same cycle: error remains set.
- seq_* outputs change only on a grant.

Decomposition:
- Package qspi_arb_pkg: arb_state_t (IDLE, LAUNCH, BUSY, DONE), owner_t (OWN_XIP, OWN_IND), default XIP_CMD constant.
- One sub-module qspi_arb_timer: the shared down-counter used as CS-gap timer in IDLE and launch-timeout in LAUNCH (load, enable, zero flag).

Test Plan:
- xip_req=1, addr=0x1000, len=8; busy rises 2 cycles after start, high 10 cycles -> xip_gnt 1 pulse, seq_addr=0x1000, seq_cmd=0xEB, xip_done 1 pulse, next grant ≥2 cycles after DONE.
- xip_req and ind_req both held continuously, short transfers -> XIP granted until starve_cnt hits 16, then ind granted with seq_cmd=ind_cmd, seq_is_ind=1.
- Grant XIP, busy never rises -> start held 8 cycles, arb_err=1, xip_done pulse; err_clr_in -> arb_err=0.
- XIP in BUSY, pulse xip_abort_in -> seq_abort_out=1 until busy falls, then xip_done, seq_abort_out=0. Repeat with owner indirect -> abort ignored.
- Assert h_rstn=0 mid-BUSY -> all outputs 0 immediately; after release with no requests, the block stays in IDLE.
